// File: rtl/adder_seq_ctrl_if.sv
// Operand/result handshake bundle between a host and adder_seq_ctrl.
// The master drives operands and accepts results; the slave is the sequencer.
interface adder_seq_ctrl_if #(
    parameter int NBYTES = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [8*NBYTES-1:0]   a;
    logic [8*NBYTES-1:0]   b;
    logic                  cin;
    logic                  out_valid;
    logic                  out_ready;
    logic [8*NBYTES-1:0]   sum;
    logic                  cout;
    logic                  ovf;
    logic                  busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/adder_seq_ctrl.sv
// Wide adder built by time-multiplexing one 8-bit ripple-carry adder,
// least-significant byte first, with valid/ready handshakes on both sides.

// Shared 8-bit ripple-carry adder datapath.
module adder_8bit (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] sum_o,
    output logic       cout_o
);
    logic [8:0] c;

    // Bit-serial carry ripple, fully combinational.
    always_comb begin
        c      = '0;
        sum_o  = '0;
        c[0]   = cin_i;
        for (int unsigned i = 0; i < 8; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o = c[8];
    end
endmodule

module adder_seq_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    adder_seq_ctrl_if.slave    bus
);
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [IDXW-1:0]         idx_q, idx_d;
    logic [NBYTES-1:0][7:0]  a_q, a_d;
    logic [NBYTES-1:0][7:0]  b_q, b_d;
    logic [NBYTES-1:0][7:0]  sum_q, sum_d;
    logic                    carry_q, carry_d;
    logic                    cout_q, cout_d;
    logic                    ovf_q, ovf_d;

    logic [7:0]              add_a;
    logic [7:0]              add_b;
    logic [7:0]              add_sum;
    logic                    add_cout;
    logic                    a_msb;
    logic                    b_msb;

    assign add_a = a_q[idx_q];
    assign add_b = b_q[idx_q];
    assign a_msb = a_q[NBYTES-1][7];
    assign b_msb = b_q[NBYTES-1][7];

    adder_8bit u_adder (
        .a_i    (add_a),
        .b_i    (add_b),
        .cin_i  (carry_q),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // State, operand, and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic: accept in IDLE, one byte per cycle in RUN, hold in DONE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[idx_q] = add_sum;
                carry_d      = add_cout;
                if (idx_q == IDX_LAST) begin
                    // idx stays on the last byte rather than wrapping.
                    cout_d  = add_cout;
                    ovf_d   = (a_msb == b_msb) && (add_sum[7] != a_msb);
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed and back-to-back checks for adder_seq_ctrl with NBYTES=4.
module tb_adder_seq_ctrl;
    localparam int NB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adder_seq_ctrl_if #(.NBYTES(NB)) bus();

    adder_seq_ctrl #(.NBYTES(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t tbl [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Present operands, accept, then wait (bounded) for out_valid.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                          output logic [31:0] s, output logic co, output logic ov,
                          output int lat);
        int n;
        bus.a = a;
        bus.b = b;
        bus.cin = cin;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            step();
            n++;
        end
        chk("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        bus.cin = 1'($urandom_range(0, 1));
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
        s = bus.sum;
        co = bus.cout;
        ov = bus.ovf;
    endtask

    initial begin
        logic [31:0] s, exp_s, last_s;
        logic        co, ov, exp_co, exp_ov;
        logic [32:0] full;
        int          lat, n, last_acc;
        logic        seen_valid;

        tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        tbl[2] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        tbl[3] = '{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0};
        tbl[4] = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000008, 1'b0, 1'b0};
        tbl[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        tbl[6] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 1'b0};
        tbl[7] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};

        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        step();
        step();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_sum", 64'(bus.sum), 64'd0);
        chk("rst_cout", 64'(bus.cout), 64'd0);
        chk("rst_ovf", 64'(bus.ovf), 64'd0);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            bus.out_ready = 1'b1;
            run_op(tbl[i].a, tbl[i].b, tbl[i].cin, s, co, ov, lat);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(NB));
            chk($sformatf("v%0d_sum", i), 64'(s), 64'(tbl[i].s));
            chk($sformatf("v%0d_cout", i), 64'(co), 64'(tbl[i].co));
            chk($sformatf("v%0d_ovf", i), 64'(ov), 64'(tbl[i].ov));
            step();
            chk($sformatf("v%0d_consumed", i), 64'(bus.out_valid), 64'd0);
            chk($sformatf("v%0d_in_ready_after", i), 64'(bus.in_ready), 64'd1);
            chk($sformatf("v%0d_sum_retained", i), 64'(bus.sum), 64'(tbl[i].s));
        end

        // Backpressure: hold result for 6 cycles, ignore an in_valid pulse
        bus.out_ready = 1'b0;
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b0, s, co, ov, lat);
        chk("bp_latency", 64'(lat), 64'(NB));
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                bus.a = 32'h11111111;
                bus.b = 32'h22222222;
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            step();
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_sum", 64'(bus.sum), 64'h7FFFFFFF);
            chk("bp_cout", 64'(bus.cout), 64'd1);
            chk("bp_ovf", 64'(bus.ovf), 64'd1);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
        chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
        chk("bp_release_busy", 64'(bus.busy), 64'd0);

        // Reset mid-RUN two cycles after accept
        bus.a = 32'hAAAAAAAA;
        bus.b = 32'h55555555;
        bus.cin = 1'b1;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        chk("mid_busy_before_rst", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sum", 64'(bus.sum), 64'd0);
        chk("mid_rst_cout", 64'(bus.cout), 64'd0);
        chk("mid_rst_ovf", 64'(bus.ovf), 64'd0);
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("mid_rel_in_ready", 64'(bus.in_ready), 64'd1);
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.out_valid) seen_valid = 1'b1;
        end
        chk("mid_no_out_valid", 64'(seen_valid), 64'd0);
        run_op(32'h00000005, 32'h00000003, 1'b0, s, co, ov, lat);
        chk("post_rst_latency", 64'(lat), 64'(NB));
        chk("post_rst_sum", 64'(s), 64'h00000008);
        step();

        // Back-to-back random operands, out_ready held high
        bus.out_ready = 1'b1;
        last_acc = 0;
        last_s = '0;
        for (int i = 0; i < 200; i++) begin
            bus.a = $urandom;
            bus.b = $urandom;
            bus.cin = 1'($urandom_range(0, 1));
            bus.in_valid = 1'b1;
            full = {1'b0, bus.a} + {1'b0, bus.b} + {32'd0, bus.cin};
            exp_s = full[31:0];
            exp_co = full[32];
            exp_ov = (bus.a[31] == bus.b[31]) && (exp_s[31] != bus.a[31]);
            n = 0;
            while (!bus.in_ready && n < 20) begin
                step();
                n++;
            end
            step();
            if (i > 0) chk("b2b_period", 64'(cyc - last_acc), 64'd6);
            last_acc = cyc;
            bus.a = $urandom;
            bus.b = $urandom;
            n = 0;
            while (!bus.out_valid && n < 20) begin
                step();
                n++;
            end
            chk("b2b_sum", 64'(bus.sum), 64'(exp_s));
            chk("b2b_cout", 64'(bus.cout), 64'(exp_co));
            chk("b2b_ovf", 64'(bus.ovf), 64'(exp_ov));
            step();
        end
        bus.in_valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adder_seq_ctrl.md
# adder_seq_ctrl

Sequencing controller that performs wide (8·NBYTES-bit) additions by time-multiplexing a single instance of the team's `adder_8bit` ripple-carry adder, one byte per cycle, least-significant byte first. Operands arrive over a valid/ready input handshake and the result leaves over a valid/ready output handshake. The block sits between a host register interface and the shared 8-bit adder datapath, and owns that adder exclusively.

## Interface
- NBYTES, 4, number of operand bytes; legal range 2..16.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  8·NBYTES  operand A, unsigned/two's-complement.
- b  in  8·NBYTES  operand B.
- cin  in  1  carry into byte 0.
- out_valid  out  1  result available; high only in DONE.
- out_ready  in  1  consumer accepts result.
- sum  out  8·NBYTES  registered result, modulo 2^(8·NBYTES).
- cout  out  1  carry out of the top byte.
- ovf  out  1  signed overflow of the full-width add.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. If in_valid is high at the edge, latch a, b, cin into a_reg, b_reg, carry_reg; set idx=0; go to RUN.
- RUN: feed a_reg[8·idx+:8], b_reg[8·idx+:8], and carry_reg into adder_8bit. On each edge write the adder sum into sum_reg[8·idx+:8], load carry_reg with the adder cout, and increment idx.
  - When idx=NBYTES-1, the edge also latches cout_reg ← adder cout and ovf_reg ← (a_msb==b_msb)&&(adder SUM≠a_msb), where a_msb=a_reg[8·NBYTES-1], b_msb=b_reg[8·NBYTES-1], and SUM is the adder MSB output. The FSM then goes to DONE.
- DONE: out_valid=1. sum, cout, ovf are held stable until out_valid&&out_ready at an edge, then the FSM returns to IDLE.
- in_valid is ignored outside IDLE. Operand inputs may change freely after acceptance.
- idx is a ceil(log2(NBYTES))-bit counter and never wraps past NBYTES-1.
- sum/cout/ovf are registered and retain the last result through IDLE and RUN of the next operation. sum bytes are overwritten progressively during RUN.
- Reset (any state, including mid-RUN): state=IDLE, idx=0, all operand registers and sum_reg=0, carry_reg=0, cout=0, ovf=0, out_valid=0, busy=0, in_ready=1 once rst_n is released. A partial result is discarded and no out_valid is produced for it.

## Timing
- Accept edge T0 (in_valid&&in_ready).
- Bytes computed on edges T0+1 … T0+NBYTES.
- out_valid rises after edge T0+NBYTES: latency NBYTES cycles from accept to out_valid.
- If out_ready is held high, the result is consumed at edge T0+NBYTES+1. in_ready is high in the following cycle, so the next accept is no earlier than T0+NBYTES+2. Minimum operation period is NBYTES+2 cycles.
- No combinational path from in_valid to in_ready or from out_ready to out_valid. The adder path is purely combinational within one cycle.
- Simultaneous reset and handshake: reset wins.

## Test plan
(All cases use NBYTES=4.)
- Carry ripple across bytes: a=0xFFFFFFFF, b=0x00000001, cin=0 → after 4 cycles out_valid=1, sum=0x00000000, cout=1, ovf=0.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, cin=0 → sum=0x80000000, cout=0, ovf=1. Also a=0x80000000, b=0x80000000 → sum=0, cout=1, ovf=1.
- cin path: a=0x12345678, b=0x11111111, cin=1 → sum=0x2345678A, cout=0, ovf=0. out_valid first asserted exactly 4 cycles after the accept edge.
- Backpressure: hold out_ready=0 for 6 cycles in DONE → out_valid stays 1, sum/cout/ovf stable, in_ready=0, and an in_valid pulse is ignored. Raise out_ready → one-edge handshake, then in_ready=1.
- Reset mid-RUN: assert rst_n=0 two cycles after accept → all outputs zero immediately (asynchronous), in_ready=1 after release, no out_valid. A subsequent add 0x00000005+0x00000003 returns 0x00000008.
- Back-to-back with random operands: 200 transactions, out_ready held high → each result matches (a+b+cin) mod 2^32, and the accept-to-accept period is exactly 6 cycles.
